// File: rtl/vec_fir_pkg.sv
// Shared types and arithmetic helpers for the streaming vector FIR engine.
package vec_fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  function automatic int acc_width(input int width, input int coef_w, input int taps);
    return width + coef_w + $clog2(taps) + 1;
  endfunction

  // Clamp a signed value into the unsigned range 0 .. 2^width-1.
  function automatic logic signed [63:0] sat_unsigned(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] max_val;
    max_val = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0) return 64'sd0;
    if (value > max_val) return max_val;
    return value;
  endfunction

endpackage

// File: rtl/vec_fir_lane.sv
// One lane of the vector FIR: sample history, per-tap products, accumulate,
// shift and saturate across two register stages.
module vec_fir_lane
  import vec_fir_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int TAPS   = 3,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        take,
  input  logic                        last,
  input  logic                        advance,
  input  logic [WIDTH-1:0]            sample,
  input  logic [TAPS-1:0][COEF_W-1:0] coef,
  output logic [WIDTH-1:0]            result
);

  localparam int PROD_W = WIDTH + 1 + COEF_W;
  localparam int ACC_W  = acc_width(WIDTH, COEF_W, TAPS);

  logic [WIDTH-1:0]         hist    [TAPS-1];
  logic signed [PROD_W-1:0] prod_d  [TAPS];
  logic signed [PROD_W-1:0] prod_p1 [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;

  // Samples are unsigned, so they gain a zero sign bit before the signed multiply.
  function automatic logic signed [PROD_W-1:0] mul(input logic [WIDTH-1:0] x,
                                                   input logic [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ce;
    xe = PROD_W'(signed'({1'b0, x}));
    ce = PROD_W'(signed'(c));
    return xe * ce;
  endfunction

  always_comb begin
    prod_d[0] = mul(sample, coef[0]);
    for (int k = 1; k < TAPS; k++) prod_d[k] = mul(hist[k-1], coef[k]);
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod_p1[k]);
    acc_sh = acc >>> SHIFT;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < TAPS - 1; k++) hist[k] <= '0;
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
      result <= '0;
    end else begin
      if (take) begin
        if (last) begin
          for (int k = 0; k < TAPS - 1; k++) hist[k] <= '0;
        end else begin
          hist[0] <= sample;
          for (int k = 1; k < TAPS - 1; k++) hist[k] <= hist[k-1];
        end
      end
      // S1: products
      if (advance) begin
        for (int k = 0; k < TAPS; k++) prod_p1[k] <= prod_d[k];
        // S2: shifted and saturated result
        result <= WIDTH'(sat_unsigned(64'(acc_sh), WIDTH));
      end
    end
  end

endmodule

// File: rtl/vec_fir_stream.sv
// Streaming vector FIR engine: shared coefficients, frame FSM and valid/ready
// handshake around LANES independent filter lanes.
module vec_fir_stream
  import vec_fir_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int WIDTH  = 20,
  parameter int TAPS   = 3,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cfg_we,
  input  logic [$clog2(TAPS)-1:0]      cfg_idx,
  input  logic [COEF_W-1:0]            cfg_coef,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  out_data,
  output logic                         out_last,
  output logic                         busy
);

  state_t                      state;
  logic                        run;
  logic                        advance;
  logic                        take;
  logic                        vld_p1;
  logic                        last_p1;
  logic                        vld_p2;
  logic                        last_p2;
  logic [TAPS-1:0][COEF_W-1:0] coef;

  // run keeps in_ready low until the first edge after reset is released.
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = run && (state != DRAIN) && advance;
  assign take      = in_valid && in_ready;
  assign out_valid = vld_p2;
  assign out_last  = last_p2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state <= in_last ? DRAIN : STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (take && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (vld_p2 && out_ready && last_p2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      run <= 1'b0;
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_W'(1 << SHIFT) : '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      run <= 1'b1;
      if (state == IDLE && cfg_we && int'(cfg_idx) < TAPS) coef[cfg_idx] <= cfg_coef;
      // S1 -> S2 control pipeline, moving in lockstep with the lane datapath
      if (advance) begin
        vld_p1  <= take;
        last_p1 <= take && in_last;
        vld_p2  <= vld_p1;
        last_p2 <= last_p1;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_fir_lane #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .COEF_W(COEF_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .take   (take),
      .last   (in_last),
      .advance(advance),
      .sample (in_data[l]),
      .coef   (coef),
      .result (out_data[l])
    );
  end

endmodule

// File: tb/tb_vec_fir_stream.sv
// Directed bench for vec_fir_stream with a frame-level reference model and
// literal expectations for each scenario.
module tb_vec_fir_stream;

  localparam int LANES  = 8;
  localparam int WIDTH  = 20;
  localparam int TAPS   = 3;
  localparam int COEF_W = 8;
  localparam int SHIFT  = 4;
  localparam longint MAXV = (64'sd1 << WIDTH) - 1;

  logic                        CLK = 1'b0;
  logic                        RST = 1'b0;
  logic                        cfg_we = 1'b0;
  logic [1:0]                  cfg_idx = '0;
  logic [COEF_W-1:0]           cfg_coef = '0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] in_data = '0;
  logic                        in_last = 1'b0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [LANES-1:0][WIDTH-1:0] out_data;
  logic                        out_last;
  logic                        busy;

  int checks = 0;
  int errors = 0;
  int spread = 1;
  bit saw_stall;

  int                          m_coef [TAPS];
  bit                          m_busy;
  logic [LANES-1:0][WIDTH-1:0] frame_q [$];
  logic [LANES-1:0][WIDTH-1:0] exp_d [$];
  logic                        exp_l [$];
  int                          got_d [$];
  logic                        got_l [$];
  bit                          hold;
  logic [LANES-1:0][WIDTH-1:0] held_d;
  logic                        held_l;
  logic [LANES-1:0][WIDTH-1:0] e_vec;
  longint                      acc;
  int                          n;
  bit                          was_busy;

  vec_fir_stream #(
    .LANES(LANES), .WIDTH(WIDTH), .TAPS(TAPS), .COEF_W(COEF_W), .SHIFT(SHIFT)
  ) dut (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_coef(cfg_coef),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic check_vec(input string name, input logic [LANES-1:0][WIDTH-1:0] act,
                           input logic [LANES-1:0][WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) m_coef[k] = (k == 0) ? (1 << SHIFT) : 0;
    frame_q.delete();
    exp_d.delete();
    exp_l.delete();
    m_busy = 1'b0;
  endfunction

  // Reference: y = clamp(floor(sum c[k]*x[n-k] / 2^SHIFT)) over the current frame.
  always @(negedge CLK) begin
    if (out_valid) begin
      if (hold) begin
        check_vec("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      if (exp_d.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        check_vec("out_data", out_data, exp_d[0]);
        check("out_last", out_last, exp_l[0]);
        if (out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          got_d.push_back(int'(out_data[0]));
          got_l.push_back(out_last);
        end
      end
    end else if (hold) begin
      check("hold_valid", out_valid, 1);
    end
    hold   = out_valid && !out_ready;
    held_d = out_data;
    held_l = out_last;
    check("busy", busy, m_busy);

    if (!RST) begin
      model_reset();
      hold = 1'b0;
    end else begin
      was_busy = m_busy;
      if (out_valid && out_ready && out_last) m_busy = 1'b0;
      if (in_valid && in_ready) begin
        frame_q.push_back(in_data);
        n = frame_q.size();
        for (int l = 0; l < LANES; l++) begin
          acc = 0;
          for (int k = 0; k < TAPS && k < n; k++)
            acc += longint'(m_coef[k]) * longint'(frame_q[n-1-k][l]);
          acc = acc >>> SHIFT;
          if (acc < 0) acc = 0;
          else if (acc > MAXV) acc = MAXV;
          e_vec[l] = WIDTH'(acc);
        end
        exp_d.push_back(e_vec);
        exp_l.push_back(in_last);
        if (in_last) frame_q.delete();
        m_busy = 1'b1;
      end
      if (cfg_we && !was_busy && int'(cfg_idx) < TAPS)
        m_coef[cfg_idx] = int'($signed(cfg_coef));
    end
  end

  task automatic send(input int val, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    for (int l = 0; l < LANES; l++) in_data[l] = WIDTH'(val + spread * l);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg(input int idx, input int val);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_coef = COEF_W'(val);
    @(posedge CLK);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy && !out_valid) break;
    end
    if (i >= 200) check("idle_timeout", 1, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_seq(input string name, input int cnt, input int e [6]);
    check({name, "_count"}, got_d.size(), cnt);
    for (int i = 0; i < cnt; i++)
      check(name, (i < got_d.size()) ? got_d[i] : -1, e[i]);
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    hold = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", out_valid, 0);
    check_vec("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rel_in_ready", in_ready, 1);
    @(posedge CLK);
    #1;

    // identity with default coefficients, plus first-beat latency
    got_d.delete();
    got_l.delete();
    send(100, 1'b0);
    @(negedge CLK);
    check("lat_early_valid", out_valid, 0);
    @(negedge CLK);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data[0], 100);
    @(posedge CLK);
    #1;
    send(200, 1'b0);
    send(300, 1'b1);
    wait_idle();
    check("id_last0", (got_l.size() > 0) ? got_l[0] : 1'bx, 0);
    check("id_last2", (got_l.size() > 2) ? got_l[2] : 1'bx, 1);
    check_seq("identity", 3, '{100, 200, 300, 0, 0, 0});

    // box filter
    cfg(0, 16);
    cfg(1, 16);
    cfg(2, 16);
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b0);
    send(40, 1'b1);
    wait_idle();
    check_seq("box", 4, '{10, 30, 60, 90, 0, 0});

    // saturation high and low
    spread = 0;
    cfg(0, 32);
    cfg(1, 0);
    cfg(2, 0);
    send(1048575, 1'b1);
    wait_idle();
    check_seq("sat_hi", 1, '{1048575, 0, 0, 0, 0, 0});
    cfg(0, 0);
    cfg(1, -16);
    send(50, 1'b0);
    send(50, 1'b1);
    wait_idle();
    check_seq("sat_lo", 2, '{0, 0, 0, 0, 0, 0});
    spread = 1;

    // backpressure
    cfg(0, 16);
    cfg(1, 16);
    cfg(2, 16);
    saw_stall = 1'b0;
    fork
      begin
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        send(40, 1'b0);
        send(50, 1'b0);
        send(60, 1'b1);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 7);
          @(negedge CLK);
          if (in_valid && !in_ready && busy) saw_stall = 1'b1;
          @(posedge CLK);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_in_ready_drop", saw_stall, 1);
    check_seq("bp", 6, '{10, 30, 60, 90, 120, 150});

    // config gating in STREAM, write alongside first beat, no history carry-over
    send(10, 1'b0);
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_coef = COEF_W'(64);
    send(20, 1'b1);
    cfg_we = 1'b0;
    wait_idle();
    cfg_idx  = 2'd0;
    cfg_coef = COEF_W'(32);
    cfg_we   = 1'b1;
    send(40, 1'b0);
    cfg_we = 1'b0;
    send(50, 1'b1);
    wait_idle();
    check_seq("cfg", 4, '{10, 30, 40, 140, 0, 0});

    // reset mid-frame with two beats in flight
    send(5, 1'b0);
    send(6, 1'b0);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("mid_rst_valid", out_valid, 0);
    check_vec("mid_rst_data", out_data, '0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    got_d.delete();
    got_l.delete();
    send(7, 1'b0);
    send(9, 1'b1);
    wait_idle();
    check_seq("post_rst", 2, '{7, 9, 0, 0, 0, 0});

    check("exp_drained", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_fir_stream.md
# vec_fir_stream

Parametrised streaming vector filter engine for the filter datapath. It takes LANES-wide vectors of unsigned WIDTH-bit samples on a valid/ready stream and applies a TAPS-tap temporal FIR independently in every lane. Coefficients are signed and programmable, and each result is shifted and saturated before it leaves the block. It sits between the vector load path and the writeback/store path. It replaces fixed 8×N vector handling with a configurable lane count, a configurable tap count, frame framing and backpressure.

## Interface
- LANES, 8, number of independent lanes
- WIDTH, 20, sample width in bits (unsigned)
- TAPS, 3, FIR taps per lane (≥2)
- COEF_W, 8, coefficient width in bits (signed, two's complement)
- SHIFT, 4, arithmetic right shift applied to the accumulator
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-low
- cfg_we  in  1  coefficient write strobe
- cfg_idx  in  $clog2(TAPS)  tap index to write
- cfg_coef  in  COEF_W  signed coefficient value
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the input beat
- in_data  in  [LANES][WIDTH]  input sample vector
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  [LANES][WIDTH]  filtered vector
- out_last  out  1  final beat of the frame
- busy  out  1  high when the FSM is not in IDLE

## Operation
- Per-lane formula: y[n] = sat(((Σk c[k]·x[n−k]) >>> SHIFT)).
  - k runs from 0 to TAPS−1.
  - x[n−k] is taken as 0 before the first beat of a frame.
- Width rules:
  - Products are computed with a signed (WIDTH+1)×COEF_W multiply.
  - The accumulator is WIDTH+COEF_W+$clog2(TAPS)+1 bits wide and signed.
  - The shift is arithmetic.
  - Saturation clamps to the range 0 … 2^WIDTH−1.
- History registers: each lane holds TAPS−1 previous samples.
  - They are cleared on reset.
  - They are cleared in the cycle after an accepted in_last beat.
- Coefficients:
  - Reset values are c[0]=1<<SHIFT and all other taps 0, which is identity.
  - cfg_we takes effect only in IDLE. In any other state it is ignored.
  - A cfg_idx ≥ TAPS is ignored.
- FSM states:
  - IDLE: in_ready=1. The first accepted beat moves to STREAM, or to DRAIN if that beat also has in_last.
  - STREAM: beats are accepted under backpressure. An accepted in_last beat moves to DRAIN.
  - DRAIN: in_ready=0. Moves to IDLE on the handshake of the out_last beat.
- Simultaneous events:
  - cfg_we in the same cycle as the first accepted beat in IDLE is honoured, and that beat uses the old coefficients.

## Timing
- The pipeline has 2 register stages.
  - S1 holds the products and the last flag.
  - S2 holds the saturated result, out_valid and out_last.
- Latency: a beat accepted at edge k is presented with out_valid=1 after edge k+1, provided the stages are not stalled.
- Advance rule: advance = !S2.valid | out_ready.
  - S1 and S2 load only on advance.
  - In IDLE/STREAM, in_ready equals advance.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_last hold stable. No beat is lost or duplicated.
- Throughput is 1 beat per cycle while out_ready stays high.
- Reset (RST=0 at an edge) puts every output at its reset value:
  - out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0
  - FSM goes to IDLE, history and pipeline are cleared, coefficients return to their reset values.
  - in_ready goes to 1 in the first cycle after reset is released.
- Reset mid-frame discards all in-flight data. No out_last is emitted for the aborted frame.

## Structure
- Shared package vec_fir_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN)
  - the accumulator width function
  - the saturation function
- One sub-module, vec_fir_lane, is instantiated LANES times. Each instance holds one lane's history, multiply, accumulate and saturation.
- Coefficients, the FSM and the handshake logic live in the top level and are shared by all lanes.

## Test plan
- Identity, after reset with the default parameters: beats of 100, 200 and 300 on all lanes, in_last on the third → out_data is 100, 200, 300 one cycle after each accept; out_last on the third beat; busy falls after that beat's handshake.
- Box filter, with c={16,16,16}: inputs 10, 20, 30, 40 → outputs 10, 30, 60, 90.
- Saturation:
  - with c[0]=32, input 1048575 → output 1048575;
  - with c={0,−16,0}, inputs 50, 50 → outputs 0, 0.
- Backpressure: stream 6 beats with out_ready low on cycles 3–7 → out_data holds during the stall, in_ready drops once both stages are full, and all 6 results arrive in order.
- Frame boundary and config gating:
  - cfg_we in STREAM leaves the coefficients unchanged;
  - after in_last, the next frame's first output equals c[0]·x>>>SHIFT, with no carry-over of history.
- Reset mid-frame: RST low in STREAM with 2 beats in flight → outputs take their reset values, and the next frame behaves exactly as after power-on.
